// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial loader/verifier for the fabric configuration flip-flop chain
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int SUB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
    logic              pass_q, pass_d;
    logic              ver_q, ver_d;
    logic              head_q, head_d;
    logic              clk_en_q, clk_en_d;
    logic              cmp_q, cmp_d;
    logic              isol_q, isol_d;
    logic              err_q, err_d;
    logic              mismatch;

    // The chain captures head on the edge that ends a clk_en cycle; in the verify
    // pass the bit leaving the tail on that same edge must equal the bit entering.
    assign mismatch = clk_en_q & cmp_q & (ccff_tail ^ head_q);

    assign s_ready     = (state_q == ST_FETCH);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign done        = (state_q == ST_FIN);
    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign isol_n      = isol_q;
    assign error       = err_q;

    // State and datapath registers; head/clk_en are flops so the clock gate sees clean edges
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sub_cnt_q <= '0;
            pass_q    <= 1'b0;
            ver_q     <= 1'b0;
            head_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            cmp_q     <= 1'b0;
            isol_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            pass_q    <= pass_d;
            ver_q     <= ver_d;
            head_q    <= head_d;
            clk_en_q  <= clk_en_d;
            cmp_q     <= cmp_d;
            isol_q    <= isol_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: one shift cycle per chain bit, one fetch cycle per word
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sub_cnt_d = sub_cnt_q;
        pass_d    = pass_q;
        ver_d     = ver_q;
        head_d    = head_q;
        clk_en_d  = 1'b0;
        cmp_d     = 1'b0;
        isol_d    = isol_q;
        err_d     = err_q | mismatch;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pass_d    = 1'b0;
                    bit_cnt_d = '0;
                    err_d     = 1'b0;
                    isol_d    = 1'b0;
                    ver_d     = verify_en;
                end
            end
            ST_FETCH: begin
                if (s_valid) begin
                    shreg_d   = s_data;
                    sub_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                head_d    = shreg_q[0];
                clk_en_d  = 1'b1;
                cmp_d     = pass_q;
                shreg_d   = shreg_q >> 1;
                sub_cnt_d = sub_cnt_q + 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    // Upper bits of a partial last word are simply never shifted
                    if (!pass_q && ver_q) begin
                        pass_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else if (sub_cnt_q == SUB_W'(WORD_W - 1)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FIN: begin
                // Last chain pulse is compared on this edge, so fold it in directly
                isol_d  = ~(err_q | mismatch);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
